// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the direct-mapped write-back data cache.
// Takes one request at a time (block refill, word load, or byte/half/word store), waits a
// programmable latency, accesses a word-organised backing array and returns one response beat.
// Optional macro DCACHE_MEM_RESP_ERR_EN: flags out-of-range addresses on rtrn_err_o instead of
// wrapping them modulo MEM_WORDS.
module dcache_mem_responder #(
  parameter int unsigned PLEN       = 34,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int          LATENCY    = 2,
  parameter int unsigned TID_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_size_i,
  input  logic [PLEN-1:0]       req_addr_i,
  input  logic [XLEN-1:0]       req_data_i,
  input  logic [TID_WIDTH-1:0]  req_tid_i,
  output logic                  rtrn_valid_o,
  output logic                  rtrn_we_o,
  output logic [TID_WIDTH-1:0]  rtrn_tid_o,
  output logic [LINE_WIDTH-1:0] rtrn_data_o,
  output logic                  rtrn_err_o
);

  localparam int unsigned Beats = LINE_WIDTH / XLEN;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OffW  = $clog2(NB);
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Word-index bits that select the word within a cache block.
  localparam logic [AW-1:0] BlockMask = AW'(Beats - 1);

  typedef enum logic [2:0] {StIdle, StWait, StRead, StWrite, StRespond} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic                  we_q, we_d;
  logic [2:0]            size_q, size_d;
  logic [PLEN-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [TID_WIDTH-1:0]  tid_q, tid_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;

  logic [XLEN-1:0] mem_q [MEM_WORDS];

  logic [AW-1:0]   widx;
  logic [OffW-1:0] off;
  logic [AW-1:0]   rd_idx;
  logic [XLEN-1:0] rd_word;
  logic [NB-1:0]   be;
  logic            is_block;
  logic            oor;
  logic            mem_we;
  logic            resp;

  assign widx     = addr_q[AW+OffW-1:OffW];
  assign off      = addr_q[OffW-1:0];
  assign is_block = (size_q == 3'b111);
  assign rd_idx   = is_block ? ((widx & ~BlockMask) | AW'(beat_q)) : widx;
  assign rd_word  = mem_q[rd_idx];

`ifdef DCACHE_MEM_RESP_ERR_EN
  logic err_q, err_d;
  assign oor = |addr_q[PLEN-1:AW+OffW];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[PLEN-1:AW+OffW];
  assign oor            = 1'b0;
`endif

  // Byte enables for the write beat; half stores are forced to an even byte offset.
  always_comb begin
    be = '0;
    case (size_q)
      3'b000: be[off] = 1'b1;
      3'b001: begin
        be[{off[OffW-1:1], 1'b0}] = 1'b1;
        be[{off[OffW-1:1], 1'b1}] = 1'b1;
      end
      default: be = '1;
    endcase
  end

  // Next-state: request latch, latency count, block beat assembly and response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tid_d   = tid_q;
    data_d  = data_q;
`ifdef DCACHE_MEM_RESP_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          addr_d  = req_addr_i;
          wdata_d = req_data_i;
          tid_d   = req_tid_i;
          cnt_d   = '0;
          beat_d  = '0;
          data_d  = '0;
`ifdef DCACHE_MEM_RESP_ERR_EN
          err_d   = 1'b0;
`endif
          if (LATENCY == 0) state_d = req_we_i ? StWrite : StRead;
          else              state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntW'(LATENCY - 1)) state_d = we_q ? StWrite : StRead;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      StRead: begin
`ifdef DCACHE_MEM_RESP_ERR_EN
        err_d = oor;
`endif
        if (is_block) begin
          // Out-of-range loads leave the response data at the zero set on accept.
          if (!oor) data_d[beat_q*XLEN +: XLEN] = rd_word;
          beat_d = beat_q + 1'b1;
          if (beat_q == BeatW'(Beats - 1)) state_d = StRespond;
        end else begin
          // Replicate into every lane so the cache can pick any word offset.
          if (!oor) data_d = {Beats{rd_word}};
          state_d = StRespond;
        end
      end
      StWrite: begin
`ifdef DCACHE_MEM_RESP_ERR_EN
        err_d = oor;
`endif
        state_d = StRespond;
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Control and response registers; reset abandons any request in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tid_q   <= '0;
      data_q  <= '0;
`ifdef DCACHE_MEM_RESP_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tid_q   <= tid_d;
      data_q  <= data_d;
`ifdef DCACHE_MEM_RESP_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign mem_we = (state_q == StWrite) && !oor;

  // Backing array write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) mem_q[widx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  assign resp         = (state_q == StRespond);
  assign req_ready_o  = (state_q == StIdle);
  assign rtrn_valid_o = resp;
  assign rtrn_we_o    = resp & we_q;
  assign rtrn_tid_o   = resp ? tid_q : '0;
  assign rtrn_data_o  = resp ? data_q : '0;
`ifdef DCACHE_MEM_RESP_ERR_EN
  assign rtrn_err_o   = resp & err_q;
`else
  assign rtrn_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Self-checking bench for dcache_mem_responder with an array-based reference model.
module tb_dcache_mem_responder;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_we;
  logic [2:0]   req_size;
  logic [33:0]  req_addr;
  logic [31:0]  req_data;
  logic [1:0]   req_tid;
  logic         req_ready_o, rtrn_valid_o, rtrn_we_o, rtrn_err_o;
  logic [1:0]   rtrn_tid_o;
  logic [127:0] rtrn_data_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem_m [1024];

  always #5 clk = ~clk;

  dcache_mem_responder #(.LATENCY(LAT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we),
    .req_size_i   (req_size),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_tid_i    (req_tid),
    .rtrn_valid_o (rtrn_valid_o),
    .rtrn_we_o    (rtrn_we_o),
    .rtrn_tid_o   (rtrn_tid_o),
    .rtrn_data_o  (rtrn_data_o),
    .rtrn_err_o   (rtrn_err_o)
  );

  // ---------------- reference model ----------------
  function automatic logic m_oor(logic [33:0] addr);
`ifdef DCACHE_MEM_RESP_ERR_EN
    return addr >= 34'h1000;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void m_store(logic [2:0] size, logic [33:0] addr, logic [31:0] data);
    int idx = int'((addr / 4) % 1024);
    int off = int'(addr % 4);
    if (m_oor(addr)) return;
    for (int b = 0; b < 4; b++) begin
      logic en;
      case (size)
        3'd0:    en = (b == off);
        3'd1:    en = (b / 2 == off / 2);
        default: en = 1'b1;
      endcase
      if (en) mem_m[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endfunction

  function automatic logic [127:0] m_load(logic [2:0] size, logic [33:0] addr);
    logic [127:0] r = '0;
    int idx = int'((addr / 4) % 1024);
    int base = idx - (idx % 4);
    if (m_oor(addr)) return r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = (size == 3'd7) ? mem_m[base + k] : mem_m[idx];
    return r;
  endfunction

  function automatic int m_lat(logic we, logic [2:0] size);
    return LAT + ((!we && size == 3'd7) ? 4 : 1) + 1;
  endfunction

  // One transaction; lat = cycles from accept edge to the rtrn_valid_o cycle, -1 on timeout.
  task automatic xact(input logic we, input logic [2:0] size, input logic [33:0] addr,
                      input logic [31:0] data, input logic [1:0] tid, output int lat,
                      output logic [127:0] rd, output logic rwe, output logic [1:0] rtid,
                      output logic rerr);
    int n = 0;
    lat = -1; rd = '0; rwe = 1'b0; rtid = '0; rerr = 1'b0;
    @(negedge clk);
    req_we = we; req_size = size; req_addr = addr; req_data = data; req_tid = tid;
    req_valid = 1'b1;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (rtrn_valid_o) begin
        lat = i; rd = rtrn_data_o; rwe = rtrn_we_o; rtid = rtrn_tid_o; rerr = rtrn_err_o;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
    n_cmp++; if (rtrn_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid got=%b exp=0", rtrn_valid_o); end
    n_cmp++; if ({rtrn_we_o, rtrn_err_o, rtrn_tid_o} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctl got=%b exp=0000", {rtrn_we_o, rtrn_err_o, rtrn_tid_o}); end
    n_cmp++; if (rtrn_data_o !== 128'b0) begin n_fail++;
      $display("FAIL reset_data got=%h exp=0", rtrn_data_o); end
  endtask

  task automatic test_block_refill();
    int lat; logic [127:0] rd; logic rwe, rerr; logic [1:0] rtid;
    logic [31:0] wv [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 3'd2, 34'h100 + 34'(4 * i), wv[i], 2'd1, lat, rd, rwe, rtid, rerr);
      m_store(3'd2, 34'h100 + 34'(4 * i), wv[i]);
      n_cmp++; if (lat !== m_lat(1'b1, 3'd2) || rwe !== 1'b1 || rd !== 128'b0) begin
        n_fail++; $display("FAIL store_resp got lat=%0d we=%b data=%h exp lat=%0d we=1 data=0",
                            lat, rwe, rd, m_lat(1'b1, 3'd2)); end
    end
    xact(1'b0, 3'd7, 34'h104, 32'h0, 2'd3, lat, rd, rwe, rtid, rerr);
    n_cmp++; if (rd !== 128'h44444444_33333333_22222222_11111111) begin n_fail++;
      $display("FAIL block_data got=%h exp=44444444333333332222222211111111", rd); end
    n_cmp++; if (lat !== 7) begin n_fail++; $display("FAIL block_lat got=%0d exp=7", lat); end
    n_cmp++; if (rtid !== 2'd3 || rwe !== 1'b0) begin n_fail++;
      $display("FAIL block_echo got tid=%0d we=%b exp tid=3 we=0", rtid, rwe); end
  endtask

  task automatic test_byte_half();
    int lat; logic [127:0] rd; logic rwe, rerr; logic [1:0] rtid;
    xact(1'b1, 3'd2, 34'h200, 32'hAABBCCDD, 2'd0, lat, rd, rwe, rtid, rerr);
    xact(1'b1, 3'd0, 34'h202, 32'h00EE0000, 2'd2, lat, rd, rwe, rtid, rerr);
    n_cmp++; if (rtid !== 2'd2 || rwe !== 1'b1) begin n_fail++;
      $display("FAIL byte_echo got tid=%0d we=%b exp tid=2 we=1", rtid, rwe); end
    xact(1'b0, 3'd2, 34'h200, 32'h0, 2'd1, lat, rd, rwe, rtid, rerr);
    n_cmp++; if (rd !== {4{32'hAAEECCDD}}) begin n_fail++;
      $display("FAIL byte_merge got=%h exp=4x AAEECCDD", rd); end
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL word_lat got=%0d exp=4", lat); end
    xact(1'b1, 3'd2, 34'h200, 32'h0, 2'd0, lat, rd, rwe, rtid, rerr);
    xact(1'b1, 3'd1, 34'h203, 32'h12340000, 2'd0, lat, rd, rwe, rtid, rerr);
    xact(1'b0, 3'd2, 34'h200, 32'h0, 2'd0, lat, rd, rwe, rtid, rerr);
    n_cmp++; if (rd[31:0] !== 32'h12340000) begin n_fail++;
      $display("FAIL half_align got=%h exp=12340000", rd[31:0]); end
    m_store(3'd2, 34'h200, 32'h12340000);
  endtask

  task automatic test_reset_mid();
    int lat; logic [127:0] rd; logic rwe, rerr; logic [1:0] rtid;
    int seen = 0;
    xact(1'b1, 3'd2, 34'h300, 32'h5555AAAA, 2'd0, lat, rd, rwe, rtid, rerr);
    m_store(3'd2, 34'h300, 32'h5555AAAA);
    @(negedge clk);
    req_we = 1'b1; req_size = 3'd2; req_addr = 34'h300; req_data = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready_o !== 1'b1 || rtrn_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL midrst_state got ready=%b valid=%b exp ready=1 valid=0",
               req_ready_o, rtrn_valid_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rtrn_valid_o) seen++; end
    n_cmp++; if (seen !== 0) begin n_fail++;
      $display("FAIL midrst_noresp got=%0d responses exp=0", seen); end
    xact(1'b0, 3'd2, 34'h300, 32'h0, 2'd0, lat, rd, rwe, rtid, rerr);
    n_cmp++; if (rd[31:0] !== 32'h5555AAAA) begin n_fail++;
      $display("FAIL midrst_mem got=%h exp=5555AAAA", rd[31:0]); end
  endtask

  task automatic test_wrap();
    int lat; logic [127:0] rd; logic rwe, rerr; logic [1:0] rtid;
    logic [127:0] exp_rd;
    xact(1'b1, 3'd2, 34'h0, 32'h01234567, 2'd0, lat, rd, rwe, rtid, rerr);
    m_store(3'd2, 34'h0, 32'h01234567);
    xact(1'b1, 3'd2, 34'h1000, 32'hDEADBEEF, 2'd1, lat, rd, rwe, rtid, rerr);
    m_store(3'd2, 34'h1000, 32'hDEADBEEF);
    n_cmp++; if (rerr !== m_oor(34'h1000) || lat !== m_lat(1'b1, 3'd2)) begin n_fail++;
      $display("FAIL wrap_store got err=%b lat=%0d exp err=%b lat=%0d",
               rerr, lat, m_oor(34'h1000), m_lat(1'b1, 3'd2)); end
    xact(1'b0, 3'd2, 34'h0, 32'h0, 2'd0, lat, rd, rwe, rtid, rerr);
    exp_rd = m_load(3'd2, 34'h0);
    n_cmp++; if (rd !== exp_rd || rerr !== 1'b0) begin n_fail++;
      $display("FAIL wrap_load0 got=%h err=%b exp=%h err=0", rd, rerr, exp_rd); end
    xact(1'b0, 3'd2, 34'h1000, 32'h0, 2'd2, lat, rd, rwe, rtid, rerr);
    exp_rd = m_load(3'd2, 34'h1000);
    n_cmp++; if (rd !== exp_rd || rerr !== m_oor(34'h1000)) begin n_fail++;
      $display("FAIL wrap_load_hi got=%h err=%b exp=%h err=%b",
               rd, rerr, exp_rd, m_oor(34'h1000)); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, first = -1, second = -1, rdy_hits = 0, rdy_at = -1;
    logic [127:0] d1 = '0, d2 = '0;
    logic [127:0] exp_rd = m_load(3'd7, 34'h100);
    @(negedge clk);
    req_we = 1'b0; req_size = 3'd7; req_addr = 34'h100; req_tid = 2'd2; req_valid = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (rtrn_valid_o) begin
        pulses++;
        if (first < 0) begin first = t; d1 = rtrn_data_o; end
        else begin second = t; d2 = rtrn_data_o; end
      end
      if (t <= 15 && req_ready_o) begin rdy_hits++; rdy_at = t; end
      if (t == 15) req_valid = 1'b0;
    end
    n_cmp++; if (pulses !== 2) begin n_fail++;
      $display("FAIL b2b_count got=%0d exp=2", pulses); end
    n_cmp++; if (first !== 7 || second !== 15) begin n_fail++;
      $display("FAIL b2b_timing got=%0d,%0d exp=7,15", first, second); end
    n_cmp++; if (rdy_hits !== 1 || rdy_at !== 8) begin n_fail++;
      $display("FAIL b2b_ready got hits=%0d at=%0d exp hits=1 at=8", rdy_hits, rdy_at); end
    n_cmp++; if (d1 !== exp_rd || d2 !== exp_rd) begin n_fail++;
      $display("FAIL b2b_data got=%h/%h exp=%h", d1, d2, exp_rd); end
  endtask

  task automatic test_random();
    int lat; logic [127:0] rd; logic rwe, rerr; logic [1:0] rtid;
    logic [33:0] a; logic [31:0] d; logic [2:0] sz; logic we; logic [1:0] tid;
    logic [127:0] exp_rd;
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      xact(1'b1, 3'd2, 34'h400 + 34'(4 * i), d, 2'd0, lat, rd, rwe, rtid, rerr);
      m_store(3'd2, 34'h400 + 34'(4 * i), d);
    end
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: sz = 3'd0;
        1: sz = 3'd1;
        2: sz = 3'd2;
        3: sz = 3'd3;
        default: sz = 3'd7;
      endcase
      if (we && sz == 3'd7) sz = 3'd2;
      a   = 34'h400 + 34'($urandom_range(0, 127));
      d   = $urandom;
      tid = 2'($urandom_range(0, 3));
      xact(we, sz, a, d, tid, lat, rd, rwe, rtid, rerr);
      if (we) begin
        m_store(sz, a, d);
        exp_rd = '0;
      end else begin
        exp_rd = m_load(sz, a);
      end
      n_cmp++;
      if (rd !== exp_rd || lat !== m_lat(we, sz) || rwe !== we || rtid !== tid
          || rerr !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_%0d we=%b sz=%0d a=%h got d=%h lat=%0d we=%b tid=%0d err=%b exp d=%h lat=%0d tid=%0d",
                 i, we, sz, a, rd, lat, rwe, rtid, rerr, exp_rd, m_lat(we, sz), tid);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_addr = '0; req_data = '0; req_tid = '0;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_block_refill();
    test_byte_half();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the direct-mapped write-back data cache.
- Accepts one cache-initiated request at a time: cache-block refill, non-cacheable word load, or word/half/byte writeback store.
- Serves each request from an internal word-organised backing array after a programmable latency, then returns one response beat.
- Used as the memory model in cache-level benches and as the scratch memory in small standalone FPGA builds.

Parameters:
- PLEN, 34, physical address width.
- XLEN, 32, memory word width in bits.
- LINE_WIDTH, 128, cache block width in bits. Must be a multiple of XLEN.
- MEM_WORDS, 1024, backing array depth in XLEN words. Must be a power of 2.
- LATENCY, 2, wait cycles between request accept and the first array access. 0 is legal.
- TID_WIDTH, 2, transaction id width.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: request ready. High only in IDLE.
- req_we_i, in, 1: 1 = store, 0 = load.
- req_size_i, in, 3: size code. 000 = byte, 001 = half, 010 = word, 011 = dword, 111 = cache block.
- req_addr_i, in, PLEN: byte address.
- req_data_i, in, XLEN: store data, byte-lane aligned to address.
- req_tid_i, in, TID_WIDTH: transaction id.
- rtrn_valid_o, out, 1: response valid. One-cycle pulse.
- rtrn_we_o, out, 1: echoes the request type.
- rtrn_tid_o, out, TID_WIDTH: echoes the request id.
- rtrn_data_o, out, LINE_WIDTH: load data. Zero for stores.
- rtrn_err_o, out, 1: error flag. Only when the optional feature is compiled in; otherwise tied 0.

Behaviour:
- Reset: all outputs 0, except req_ready_o = 1. State = IDLE. Array contents are not reset.
- Reset mid-operation: return to IDLE immediately. Pending response is dropped. A store not yet in WRITE is not committed.
- Accept: request is taken on a rising edge with req_valid_i && req_ready_o. Latch we, size, addr, data and tid. No back-to-back accept; ready drops the cycle after accept.
- Word index: widx = addr[log2(MEM_WORDS)+1:2], modulo MEM_WORDS, so it wraps at the top of the array.
- States and transitions:
  - IDLE -> WAIT on accept, or directly to the access state if LATENCY = 0.
  - WAIT: count LATENCY cycles, then go to READ (loads) or WRITE (stores).
  - READ, cache block (size 111): base = widx with the low log2(LINE_WIDTH/XLEN) bits cleared. Beat k reads word base+k into rtrn_data_o[k*XLEN +: XLEN]. One beat per cycle; LINE_WIDTH/XLEN beats (4 by default). Beat counter wraps inside the block only.
  - READ, any other load size: one beat. The word at widx is replicated into every XLEN lane of rtrn_data_o, so the cache can extract it at any word offset.
  - WRITE: one cycle. Byte enable from off = addr[1:0]:
    - byte: be[off] = 1.
    - half: off[0] is forced to 0, then be[off +: 2] = 1.
    - word and dword: be = 4'b1111. Dword is treated as a word at XLEN = 32.
    - Enabled lanes of req_data_i are written at widx.
  - RESPOND: one cycle. rtrn_valid_o = 1, with we/tid echoed and data held stable. Then go to IDLE.
- Latency, accept edge to the rtrn_valid_o cycle:
  - Cache-block load: LATENCY + LINE_WIDTH/XLEN + 1 cycles (7 by default).
  - Word load: LATENCY + 2.
  - Store: LATENCY + 2.
- A store followed by a load to the same address returns the new data.
- req_valid_i while busy is ignored and must be held by the initiator.

Optional Feature:
- Macro: DCACHE_MEM_RESP_ERR_EN.
- Defined: a request with addr[PLEN-1:log2(MEM_WORDS)+2] != 0 is out of range.
  - A load returns rtrn_data_o = 0 with rtrn_err_o = 1.
  - A store is not written and responds with rtrn_err_o = 1.
  - Timing is unchanged.
- Undefined: no range check. Addresses wrap modulo MEM_WORDS and rtrn_err_o is tied 0.

Test Plan:
- Word stores 0x11111111, 0x22222222, 0x33333333 and 0x44444444 to 0x100 to 0x10C, then a size-111 load at 0x104 -> rtrn_data_o = 0x44444444_33333333_22222222_11111111, rtrn_valid_o 7 cycles after accept, tid echoed.
- Word 0xAABBCCDD at 0x200, then a byte store of data 0x00EE0000 at 0x202, then a word load -> all four lanes = 0xAAEECCDD.
- Half store of 0x12340000 at 0x203 (forced to offset 2) over 0 -> word at 0x200 = 0x12340000.
- Assert rst_ni low during WAIT of a store to 0x300 -> no response, req_ready_o = 1, word at 0x300 unchanged.
- Store 0xDEADBEEF to 0x1000 (widx wraps to 0) -> load at 0x0 returns 0xDEADBEEF without the macro. With DCACHE_MEM_RESP_ERR_EN defined: rtrn_err_o = 1 and the word at 0x0 is unchanged.
- Hold req_valid_i high during a cache-block load -> second request accepted only the cycle after rtrn_valid_o, exactly one response per accept.
